// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage: command field layout,
// flag bit positions and the stage state encoding.
package operand_fetch_pkg;

    localparam int SRC0_LSB = 0;
    localparam int SRC1_LSB = 8;
    localparam int DST_LSB  = 16;
    localparam int OPC_LSB  = 28;
    localparam int OPC_W    = 4;

    localparam int F_SRC0_PTR = 24;
    localparam int F_SRC1_PTR = 25;
    localparam int F_DST_PTR  = 26;
    localparam int F_SRC1_EN  = 27;

    typedef enum logic [2:0] {
        OF_IDLE,
        OF_S0,
        OF_S0P,
        OF_S1,
        OF_S1P,
        OF_D,
        OF_DONE
    } of_state_t;

    // States whose only work is a single operand read.
    function automatic logic is_operand_read(input of_state_t s);
        return (s == OF_S0) || (s == OF_S0P) || (s == OF_S1) || (s == OF_S1P);
    endfunction

endpackage

// File: rtl/operand_fetch_bus_read_port.sv
// One-read-at-a-time bus master: issues a single read while start is held and
// reports the data when the bus echoes back the same address.
module operand_fetch_bus_read_port #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              disp_online,
    input  logic              bus_busy,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rd_q,
    output logic              bus_halt_q,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              bus_rd_dn,
    input  logic [ADDR_W-1:0] bus_addr_in
);

    logic issued;

    assign bus_rd_q   = start && !issued && disp_online && !bus_busy;
    assign bus_halt_q = bus_rd_q;
    assign bus_addr   = start ? addr : '0;
    assign rvalid     = start && issued && bus_rd_dn && (bus_addr_in == addr);
    assign rdata      = bus_data;

    // Losing the grant mid-wait forgets the request so the same address is re-issued.
    always_ff @(posedge clk) begin
        if (rst || !start || rvalid) begin
            issued <= 1'b0;
        end else if (bus_rd_q) begin
            issued <= 1'b1;
        end else if (!disp_online) begin
            issued <= 1'b0;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: decodes the command's register fields and reads the
// operands (with optional one-level indirection) over the shared memory bus.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [31:0]       command,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] cmd_ptr,
    input  logic              disp_online,
    input  logic              bus_busy,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rd_q,
    output logic              bus_halt_q,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              bus_rd_dn,
    input  logic [ADDR_W-1:0] bus_addr_in,
    output logic              busy,
    output logic              done,
    output logic [3:0]        opcode,
    output logic [DATA_W-1:0] src0_val,
    output logic [DATA_W-1:0] src1_val,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [ADDR_W-1:0] cmd_ptr_o
);

    of_state_t         state;
    of_state_t         next_state;
    logic [31:0]       cmd_q;
    logic [ADDR_W-1:0] base_q;

    logic              rd_start;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    logic [IDX_W-1:0]  src0_idx;
    logic [IDX_W-1:0]  src1_idx;
    logic [IDX_W-1:0]  dst_idx;
    logic              src0_ptr;
    logic              src1_ptr;
    logic              dst_ptr;
    logic              src1_en;

    assign src0_idx = cmd_q[SRC0_LSB +: IDX_W];
    assign src1_idx = cmd_q[SRC1_LSB +: IDX_W];
    assign dst_idx  = cmd_q[DST_LSB +: IDX_W];
    assign src0_ptr = cmd_q[F_SRC0_PTR];
    assign src1_ptr = cmd_q[F_SRC1_PTR];
    assign dst_ptr  = cmd_q[F_DST_PTR];
    assign src1_en  = cmd_q[F_SRC1_EN];
    assign opcode   = cmd_q[OPC_LSB +: OPC_W];

    assign done = (state == OF_DONE);
    assign busy = (state != OF_IDLE) && (state != OF_DONE);

    // Register addresses wrap modulo 2^ADDR_W by truncation of the sum.
    function automatic logic [ADDR_W-1:0] reg_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [IDX_W-1:0]  idx);
        return base + ADDR_W'(idx);
    endfunction

    operand_fetch_bus_read_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rd_port (
        .clk         (clk),
        .rst         (rst),
        .start       (rd_start),
        .addr        (rd_addr),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .disp_online (disp_online),
        .bus_busy    (bus_busy),
        .bus_addr    (bus_addr),
        .bus_rd_q    (bus_rd_q),
        .bus_halt_q  (bus_halt_q),
        .bus_data    (bus_data),
        .bus_rd_dn   (bus_rd_dn),
        .bus_addr_in (bus_addr_in)
    );

    always_comb begin
        next_state = state;
        rd_start   = 1'b0;
        rd_addr    = '0;
        case (state)
            OF_IDLE: begin
                if (cmd_valid) next_state = OF_S0;
            end
            OF_S0: begin
                rd_start = 1'b1;
                rd_addr  = reg_addr(base_q, src0_idx);
                if (rvalid) next_state = src0_ptr ? OF_S0P : (src1_en ? OF_S1 : OF_D);
            end
            // The pointer read reuses src0_val, which holds the register value.
            OF_S0P: begin
                rd_start = 1'b1;
                rd_addr  = ADDR_W'(src0_val);
                if (rvalid) next_state = src1_en ? OF_S1 : OF_D;
            end
            OF_S1: begin
                rd_start = 1'b1;
                rd_addr  = reg_addr(base_q, src1_idx);
                if (rvalid) next_state = src1_ptr ? OF_S1P : OF_D;
            end
            OF_S1P: begin
                rd_start = 1'b1;
                rd_addr  = ADDR_W'(src1_val);
                if (rvalid) next_state = OF_D;
            end
            OF_D: begin
                rd_start = dst_ptr;
                rd_addr  = reg_addr(base_q, dst_idx);
                if (!dst_ptr || rvalid) next_state = OF_DONE;
            end
            OF_DONE: begin
                next_state = OF_IDLE;
            end
            default: begin
                next_state = OF_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= OF_IDLE;
            cmd_q     <= '0;
            base_q    <= '0;
            cmd_ptr_o <= '0;
            src0_val  <= '0;
            src1_val  <= '0;
            dst_addr  <= '0;
        end else begin
            state <= next_state;
            case (state)
                OF_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q     <= command;
                        base_q    <= base_addr;
                        cmd_ptr_o <= cmd_ptr;
                        src1_val  <= '0;
                    end
                end
                OF_S0, OF_S0P: begin
                    if (rvalid) src0_val <= rdata;
                end
                OF_S1, OF_S1P: begin
                    if (rvalid) src1_val <= rdata;
                end
                OF_D: begin
                    if (!dst_ptr) begin
                        dst_addr <= reg_addr(base_q, dst_idx);
                    end else if (rvalid) begin
                        dst_addr <= ADDR_W'(rdata);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Reads are only ever requested from the operand states or a pointer destination.
    logic unused_check;
    assign unused_check = is_operand_read(state);

endmodule

// File: tb/tb_operand_fetch.sv
// Randomised scoreboard bench for operand_fetch: a memory responder serves bus
// reads while a monitor compares each done pulse against a reference model.
module tb_operand_fetch;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic [31:0]       command;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] cmd_ptr;
    logic              disp_online;
    logic              bus_busy;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_rd_q;
    logic              bus_halt_q;
    logic [DATA_W-1:0] bus_data;
    logic              bus_rd_dn;
    logic [ADDR_W-1:0] bus_addr_in;
    logic              busy;
    logic              done;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] src0_val;
    logic [DATA_W-1:0] src1_val;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W-1:0] cmd_ptr_o;

    always #5 clk = ~clk;

    operand_fetch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .command     (command),
        .base_addr   (base_addr),
        .cmd_ptr     (cmd_ptr),
        .disp_online (disp_online),
        .bus_busy    (bus_busy),
        .bus_addr    (bus_addr),
        .bus_rd_q    (bus_rd_q),
        .bus_halt_q  (bus_halt_q),
        .bus_data    (bus_data),
        .bus_rd_dn   (bus_rd_dn),
        .bus_addr_in (bus_addr_in),
        .busy        (busy),
        .done        (done),
        .opcode      (opcode),
        .src0_val    (src0_val),
        .src1_val    (src1_val),
        .dst_addr    (dst_addr),
        .cmd_ptr_o   (cmd_ptr_o)
    );

    typedef struct {
        logic [3:0]  opc;
        logic [31:0] src0;
        logic [31:0] src1;
        logic [31:0] dst;
        logic [31:0] cptr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_reads[$];
    logic [31:0] mem[bit [31:0]];

    int compared   = 0;
    int mismatched = 0;
    int done_count = 0;
    int force_mode = -1;
    bit hold_resp  = 1'b0;
    bit prev_done  = 1'b0;

    // Memory contents: explicit entries, otherwise a fixed scrambling of the address.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Reference model: list of bus reads and final operands for one command.
    task automatic predict(input logic [31:0] cmd, input logic [31:0] base,
                           input logic [31:0] cptr);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] v;
        e.opc  = cmd[31:28];
        e.cptr = cptr;
        a = base + {24'h0, cmd[7:0]};
        exp_reads.push_back(a);
        v = mem_rd(a);
        if (cmd[24]) begin
            exp_reads.push_back(v);
            v = mem_rd(v);
        end
        e.src0 = v;
        e.src1 = 32'h0;
        if (cmd[27]) begin
            a = base + {24'h0, cmd[15:8]};
            exp_reads.push_back(a);
            v = mem_rd(a);
            if (cmd[25]) begin
                exp_reads.push_back(v);
                v = mem_rd(v);
            end
            e.src1 = v;
        end
        a = base + {24'h0, cmd[23:16]};
        if (cmd[26]) begin
            exp_reads.push_back(a);
            e.dst = mem_rd(a);
        end else begin
            e.dst = a;
        end
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [31:0] cmd, input logic [31:0] base,
                                 input logic [31:0] cptr, input bit shake);
        int start_cnt;
        int hold_busy;
        predict(cmd, base, cptr);
        @(posedge clk);
        #1;
        command   = cmd;
        base_addr = base;
        cmd_ptr   = cptr;
        cmd_valid = 1'b1;
        hold_busy = (shake && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        bus_busy  = (hold_busy != 0);
        start_cnt = done_count;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        command   = $urandom;
        base_addr = $urandom;
        cmd_ptr   = $urandom;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        for (int i = 0; i < hold_busy; i++) @(posedge clk);
        #1;
        bus_busy = 1'b0;
        if (shake && busy) begin
            // A second command while busy must be ignored.
            @(posedge clk);
            #1;
            cmd_valid = 1'b1;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end
        for (int i = 0; i < 400 && done_count == start_cnt; i++) @(posedge clk);
        if (done_count == start_cnt) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL done_timeout: actual=no done expected=done for cmd %h", cmd);
            sb.delete();
            exp_reads.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every done pulse and checks bus rules.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus_rd_q || bus_halt_q) begin
                checkOutput("halt_matches_rd", 32'(bus_halt_q), 32'(bus_rd_q));
                checkOutput("issue_granted", {30'h0, bus_busy, disp_online}, 32'd1);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_done: actual=done expected=no done");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("src0_val", src0_val, e.src0);
                    checkOutput("src1_val", src1_val, e.src1);
                    checkOutput("dst_addr", dst_addr, e.dst);
                    checkOutput("opcode", 32'(opcode), 32'(e.opc));
                    checkOutput("cmd_ptr_o", cmd_ptr_o, e.cptr);
                    checkOutput("busy_at_done", 32'(busy), 32'd0);
                    checkOutput("reads_outstanding", 32'(exp_reads.size()), 32'd0);
                    checkOutput("done_single_pulse", 32'(prev_done), 32'd0);
                end
                done_count++;
            end
        end
        prev_done = (done === 1'b1);
    end

    // Bus responder: mode 0 drops the grant mid-wait, mode 1 sends a stray
    // completion first, otherwise a plain delayed completion.
    initial begin : responder
        logic [31:0] addr;
        logic [31:0] reissue_addr;
        int          mode;
        bit          reissue_pending;
        reissue_pending = 1'b0;
        reissue_addr    = '0;
        forever begin
            @(negedge clk);
            if (bus_rd_q === 1'b1 && rst === 1'b0) begin
                addr = bus_addr;
                if (reissue_pending) begin
                    checkOutput("reissue_addr", addr, reissue_addr);
                    reissue_pending = 1'b0;
                end else if (exp_reads.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_read: actual=%h expected=no read", addr);
                end else begin
                    checkOutput("read_addr", addr, exp_reads.pop_front());
                end
                mode = (force_mode >= 0) ? force_mode : int'($urandom_range(0, 5));
                force_mode = -1;
                @(posedge clk);
                #1;
                if (hold_resp) begin
                    while (hold_resp) @(posedge clk);
                    #1;
                    bus_addr_in = addr;
                    bus_data    = mem_rd(addr);
                    bus_rd_dn   = 1'b1;
                    @(posedge clk);
                    #1;
                    bus_rd_dn   = 1'b0;
                    bus_addr_in = '0;
                end else if (mode == 0) begin
                    disp_online = 1'b0;
                    repeat ($urandom_range(1, 2)) @(posedge clk);
                    #1;
                    disp_online     = 1'b1;
                    reissue_pending = 1'b1;
                    reissue_addr    = addr;
                end else begin
                    if (mode == 1) begin
                        bus_addr_in = (addr == 32'hDEAD) ? 32'hBEEF : 32'hDEAD;
                        bus_data    = 32'hBAD0_BAD0;
                        bus_rd_dn   = 1'b1;
                        @(posedge clk);
                        #1;
                        bus_rd_dn = 1'b0;
                    end
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    bus_addr_in = addr;
                    bus_data    = mem_rd(addr);
                    bus_rd_dn   = 1'b1;
                    @(posedge clk);
                    #1;
                    bus_rd_dn   = 1'b0;
                    bus_addr_in = '0;
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: actual=still running expected=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin : main
        int saved;
        rst         = 1'b1;
        cmd_valid   = 1'b1;
        command     = 32'h0800_0201;
        base_addr   = 32'h100;
        cmd_ptr     = 32'h44;
        disp_online = 1'b1;
        bus_busy    = 1'b0;
        bus_rd_dn   = 1'b0;
        bus_addr_in = '0;
        bus_data    = '0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_rd_q", 32'(bus_rd_q), 32'd0);
            checkOutput("rst_done", 32'(done), 32'd0);
        end
        checkOutput("rst_src0", src0_val, 32'd0);
        checkOutput("rst_dst", dst_addr, 32'd0);
        checkOutput("rst_cmd_ptr", cmd_ptr_o, 32'd0);
        rst       = 1'b0;
        cmd_valid = 1'b0;

        mem[32'h101]  = 32'hAA;
        mem[32'h102]  = 32'hBB;
        mem[32'h105]  = 32'h2000;
        mem[32'h2000] = 32'h1234;

        $display("[TB] directed: plain two-operand fetch");
        force_mode = 2;
        applyStimulus(32'h0800_0201, 32'h100, 32'h40, 1'b0);
        $display("[TB] directed: src0 indirection");
        force_mode = 2;
        applyStimulus(32'hA100_0005, 32'h100, 32'h48, 1'b0);
        $display("[TB] directed: grant dropped during wait");
        force_mode = 0;
        applyStimulus(32'h0800_0201, 32'h100, 32'h50, 1'b0);
        $display("[TB] directed: stray completion address");
        force_mode = 1;
        applyStimulus(32'h0800_0201, 32'h100, 32'h58, 1'b0);
        $display("[TB] directed: register address wrap");
        force_mode = 2;
        applyStimulus(32'h0800_0302, 32'hFFFF_FFFF, 32'h60, 1'b0);
        $display("[TB] directed: pointer destination");
        force_mode = 2;
        applyStimulus(32'h5400_0703, 32'h100, 32'h68, 1'b0);

        $display("[TB] directed: reset during wait");
        hold_resp = 1'b1;
        exp_reads.push_back(32'h211);
        @(posedge clk);
        #1;
        command   = 32'h0000_0011;
        base_addr = 32'h200;
        cmd_ptr   = 32'h77;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("busy_in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("busy_after_rst", 32'(busy), 32'd0);
        checkOutput("rd_q_after_rst", 32'(bus_rd_q), 32'd0);
        checkOutput("cmd_ptr_after_rst", cmd_ptr_o, 32'd0);
        saved     = done_count;
        hold_resp = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("no_done_after_rst", 32'(done_count), 32'(saved));

        $display("[TB] random commands");
        for (int n = 0; n < 40; n++) begin
            logic [31:0] rb;
            rb = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 32'h3FF));
            applyStimulus($urandom, rb, $urandom, 1'b1);
        end

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
